// File: rtl/z_sdpram_be_if.sv
// Bus bundle for z_sdpram_be: write port, read port and qualified read data.
// master drives requests, slave is the RAM.
interface z_sdpram_be_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 128,
    parameter int BYTE_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  ena_w;
    logic [NB-1:0]         wea;
    logic [ADDR_WIDTH-1:0] addr_w;
    logic [DATA_WIDTH-1:0] din;
    logic                  ena_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_vld;

    modport master (
        output ena_w, wea, addr_w, din,
        output ena_r, addr_r,
        input  dout, dout_vld
    );

    modport slave (
        input  ena_w, wea, addr_w, din,
        input  ena_r, addr_r,
        output dout, dout_vld
    );
endinterface

// File: rtl/z_sdpram_be.sv
// Simple dual-port RAM with byte write enables, selectable read-during-write
// policy and a reset-cleared read-valid pipeline of LATENCY stages.
module z_sdpram_be #(
    parameter int    ADDR_WIDTH = 8,
    parameter int    DATA_WIDTH = 128,
    parameter int    BYTE_WIDTH = 8,
    parameter int    DEPTH      = 192,
    parameter int    LATENCY    = 2,
    parameter string RDW_MODE   = "read_first",
    parameter string RAMTYPE    = "auto"
) (
    input  logic          clk,
    input  logic          rst,
    z_sdpram_be_if.slave  bus
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam bit WRITE_FIRST = (RDW_MODE == "write_first");

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_bw
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (LATENCY < 1) begin : g_bad_lat
        $error("LATENCY must be >= 1");
    end
    if (ADDR_WIDTH < IDX_W) begin : g_bad_aw
        $error("ADDR_WIDTH too small for DEPTH");
    end
    if (RDW_MODE != "read_first" && RDW_MODE != "write_first") begin : g_bad_rdw
        $error("RDW_MODE must be read_first or write_first");
    end
    if (RAMTYPE != "auto" && RAMTYPE != "block" &&
        RAMTYPE != "distributed" && RAMTYPE != "register") begin : g_bad_rt
        $error("RAMTYPE must be auto, block, distributed or register");
    end

    (* ram_style = RAMTYPE *)
    logic [DATA_WIDTH-1:0] r_ram [DEPTH];

    logic [DATA_WIDTH-1:0] r_data [LATENCY];
    logic [LATENCY-1:0]    r_vld;

    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_collide;
    logic [IDX_W-1:0]      w_wr_idx;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_wr_ok   = bus.ena_w && ({1'b0, bus.addr_w} < DEPTH_L);
    assign w_rd_ok   = {1'b0, bus.addr_r} < DEPTH_L;
    assign w_wr_idx  = bus.addr_w[IDX_W-1:0];
    assign w_rd_idx  = bus.addr_r[IDX_W-1:0];
    assign w_collide = w_wr_ok && (bus.addr_w == bus.addr_r);
    assign w_rd_word = r_ram[w_rd_idx];

    // Out-of-range reads return zero; write_first merges enabled din lanes.
    always_comb begin
        w_rd_data = '0;
        if (w_rd_ok) begin
            w_rd_data = w_rd_word;
            if (WRITE_FIRST && w_collide) begin
                for (int k = 0; k < NB; k++) begin
                    if (bus.wea[k]) begin
                        w_rd_data[k*BYTE_WIDTH +: BYTE_WIDTH] =
                            bus.din[k*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            for (int k = 0; k < NB; k++) begin
                if (bus.wea[k]) begin
                    r_ram[w_wr_idx][k*BYTE_WIDTH +: BYTE_WIDTH] <=
                        bus.din[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0] <= bus.ena_r;
            if (bus.ena_r) begin
                r_data[0] <= w_rd_data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign bus.dout     = r_data[LATENCY-1];
    assign bus.dout_vld = r_vld[LATENCY-1];
endmodule

// File: tb/tb_z_sdpram_be.sv
// Scoreboard bench: one read_first and one write_first instance share stimulus;
// expected reads are queued per instance and popped by a negedge monitor.
module tb_z_sdpram_be;
    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int LAT = 2;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          ena_w  = 1'b0;
    logic [3:0]    wea    = '0;
    logic [AW-1:0] addr_w = '0;
    logic [DW-1:0] din    = '0;
    logic          ena_r  = 1'b0;
    logic [AW-1:0] addr_r = '0;

    z_sdpram_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8)) if_rf ();
    z_sdpram_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8)) if_wf ();

    assign if_rf.ena_w  = ena_w;
    assign if_rf.wea    = wea;
    assign if_rf.addr_w = addr_w;
    assign if_rf.din    = din;
    assign if_rf.ena_r  = ena_r;
    assign if_rf.addr_r = addr_r;
    assign if_wf.ena_w  = ena_w;
    assign if_wf.wea    = wea;
    assign if_wf.addr_w = addr_w;
    assign if_wf.din    = din;
    assign if_wf.ena_r  = ena_r;
    assign if_wf.addr_r = addr_r;

    z_sdpram_be #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .DEPTH(12),
        .LATENCY(LAT), .RDW_MODE("read_first"), .RAMTYPE("auto")
    ) u_rf (.clk(clk), .rst(rst), .bus(if_rf));

    z_sdpram_be #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .DEPTH(12),
        .LATENCY(LAT), .RDW_MODE("write_first"), .RAMTYPE("auto")
    ) u_wf (.clk(clk), .rst(rst), .bus(if_wf));

    logic [31:0] dout_a [2];
    logic        vld_a  [2];
    assign dout_a[0] = if_rf.dout;
    assign dout_a[1] = if_wf.dout;
    assign vld_a[0]  = if_rf.dout_vld;
    assign vld_a[1]  = if_wf.dout_vld;

    exp_t        q [2][$];
    logic [31:0] last [2];
    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc     = 0;
    bit          started = 1'b0;

    task automatic chk(input string name, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d cyc=%0d got=%h want=%h",
                      name, d, cyc, act, exp);
    endtask

    always @(posedge clk) begin
        cyc++;
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    last[d] = '0;
                    chk("rst_dout", d, dout_a[d], 32'h0);
                    chk("rst_vld", d, 32'(vld_a[d]), 32'h0);
                end else if (vld_a[d]) begin
                    if (q[d].size() == 0) begin
                        chk("unexpected_vld", d, 32'h1, 32'h0);
                    end else begin
                        exp_t e;
                        e = q[d].pop_front();
                        chk("rd_data", d, dout_a[d], e.data);
                        chk("rd_cycle", d, 32'(cyc), 32'(e.due));
                        last[d] = e.data;
                    end
                end else begin
                    chk("hold", d, dout_a[d], last[d]);
                end
            end
        end
    end

    task automatic op(input logic we, input logic [3:0] be,
                      input logic [AW-1:0] aw, input logic [31:0] d,
                      input logic re, input logic [AW-1:0] ar,
                      input logic [31:0] erf, input logic [31:0] ewf);
        exp_t e;
        ena_w  = we;
        wea    = be;
        addr_w = aw;
        din    = d;
        ena_r  = re;
        addr_r = ar;
        if (re) begin
            e.due  = cyc + LAT;
            e.data = erf;
            q[0].push_back(e);
            e.data = ewf;
            q[1].push_back(e);
        end
        @(posedge clk);
        #1;
        ena_w = 1'b0;
        ena_r = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        op(1'b1, be, a, d, 1'b0, '0, '0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [31:0] e);
        op(1'b0, 4'h0, '0, '0, 1'b1, a, e, e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("init_dout_rf", 0, if_rf.dout, 32'h0);
        chk("init_vld_wf", 1, 32'(if_wf.dout_vld), 32'h0);
        rst = 1'b0;

        for (int a = 0; a < 12; a++) begin
            wr(AW'(a), (a == 7) ? 32'h0 : 32'(a) * 32'h01010101, 4'hF);
        end

        wr(4'd3, 32'hDEADBEEF, 4'hF);
        rd(4'd3, 32'hDEADBEEF);
        idle(4);

        wr(4'd5, 32'h11223344, 4'hF);
        wr(4'd5, 32'hAABBCCDD, 4'b0101);
        rd(4'd5, 32'h11BB33DD);
        idle(3);

        op(1'b1, 4'b0011, 4'd7, 32'hFFFFFFFF, 1'b1, 4'd7,
           32'h00000000, 32'h0000FFFF);
        rd(4'd7, 32'h0000FFFF);
        idle(3);

        wr(4'd3, 32'h03030303, 4'hF);
        wr(4'd5, 32'h05050505, 4'hF);
        for (int a = 0; a < 6; a++) begin
            rd(AW'(a), 32'(a) * 32'h01010101);
        end
        idle(3);

        wr(4'd12, 32'h12345678, 4'hF);
        rd(4'd12, 32'h0);
        rd(4'd11, 32'h0B0B0B0B);
        rd(4'd4, 32'h04040404);
        idle(3);

        ena_r  = 1'b1;
        addr_r = 4'd1;
        @(posedge clk);
        #1;
        addr_r = 4'd2;
        @(posedge clk);
        #1;
        ena_r = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_dout_rf", 0, if_rf.dout, 32'h0);
        chk("async_rst_vld_rf", 0, 32'(if_rf.dout_vld), 32'h0);
        chk("async_rst_dout_wf", 1, if_wf.dout, 32'h0);
        chk("async_rst_vld_wf", 1, 32'(if_wf.dout_vld), 32'h0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        idle(5);
        rd(4'd1, 32'h01010101);

        for (int i = 0; i < 20; i++) begin
            if (q[0].size() == 0 && q[1].size() == 0) break;
            idle(1);
        end
        chk("drain_rf", 0, 32'(q[0].size()), 32'h0);
        chk("drain_wf", 1, 32'(q[1].size()), 32'h0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
